// File: rtl/display_scanner.sv
// display_scanner
// Time-multiplexed scanner for a four-digit seven-segment display.
// Each digit slot lasts DIV clock cycles. The first GUARD cycles of a slot
// are forced dark so the previous digit cannot ghost onto the next anode.
// Values are displayed from a shadow register. A load made mid-frame is
// parked in a pending register and committed at the next frame boundary.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   enable      1 = scan, 0 = dark and idle
//   value_in    four hex digits, [3:0] = digit 0 (rightmost)
//   load        one-cycle strobe that captures value_in
//   digit_en    per-digit enable mask
//   lz_en       leading-zero suppression
//   rank        index of the driven digit (registered)
//   blank       0 = selected digit lit, 1 = dark (registered)
//   digit_data  nibble for the selected digit (registered)
//   frame_done  one-cycle pulse after the digit 3 slot ends
//   pending     a loaded value is waiting for the frame boundary
//
// state  | meaning
// IDLE   | scanner stopped, display dark
// GUARD  | start of a slot, anode blanked
// SHOW   | rest of the slot, digit lit unless masked or suppressed
module display_scanner #(
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  output logic [1:0]  rank,
  output logic        blank,
  output logic [3:0]  digit_data,
  output logic        frame_done,
  output logic        pending
);

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_SHOW} state_t;

  localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
  localparam logic [15:0] GUARD_LEN = 16'(GUARD);

  state_t      state, state_n;
  logic [15:0] slot_cnt, slot_cnt_n;
  logic [1:0]  rank_n;
  logic [15:0] shadow, shadow_n;
  logic [15:0] pend_reg, pend_reg_n;
  logic        pending_n;
  logic        slot_dark, slot_dark_n;
  logic [3:0]  data_n;
  logic        blank_n;
  logic        frame_done_n;

  logic        slot_end;
  logic        boundary;
  logic        slot_start;
  logic        sup;
  logic [3:0]  nib;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      slot_cnt   <= '0;
      rank       <= '0;
      shadow     <= '0;
      pend_reg   <= '0;
      pending    <= 1'b0;
      slot_dark  <= 1'b1;
      digit_data <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      slot_cnt   <= slot_cnt_n;
      rank       <= rank_n;
      shadow     <= shadow_n;
      pend_reg   <= pend_reg_n;
      pending    <= pending_n;
      slot_dark  <= slot_dark_n;
      digit_data <= data_n;
      blank      <= blank_n;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    slot_cnt_n   = slot_cnt;
    rank_n       = rank;
    shadow_n     = shadow;
    pend_reg_n   = pend_reg;
    pending_n    = pending;
    slot_dark_n  = slot_dark;
    data_n       = digit_data;
    blank_n      = 1'b1;
    frame_done_n = 1'b0;
    sup          = 1'b0;
    nib          = 4'h0;

    slot_end   = (state != ST_IDLE) && (slot_cnt == CNT_LAST);
    boundary   = slot_end && (rank == 2'd3);
    slot_start = enable && ((state == ST_IDLE) || slot_end);

    // sequencing
    if (!enable) begin
      state_n    = ST_IDLE;
      slot_cnt_n = '0;
      rank_n     = '0;
    end else if (state == ST_IDLE) begin
      state_n    = ST_GUARD;
      slot_cnt_n = '0;
      rank_n     = '0;
    end else if (slot_end) begin
      state_n    = ST_GUARD;
      slot_cnt_n = '0;
      rank_n     = rank + 2'd1;
    end else begin
      slot_cnt_n = slot_cnt + 16'd1;
      state_n    = (slot_cnt_n >= GUARD_LEN) ? ST_SHOW : ST_GUARD;
    end

    // a load at the boundary supersedes any parked value
    if (state == ST_IDLE) begin
      if (load) begin
        shadow_n  = value_in;
        pending_n = 1'b0;
      end
    end else if (boundary) begin
      if (load) begin
        shadow_n  = value_in;
        pending_n = 1'b0;
      end else if (pending) begin
        shadow_n  = pend_reg;
        pending_n = 1'b0;
      end
    end else if (load) begin
      pend_reg_n = value_in;
      pending_n  = 1'b1;
    end

    // digit selection and suppression are frozen for the whole slot
    case (rank_n)
      2'd0: begin nib = shadow_n[3:0];   sup = 1'b0; end
      2'd1: begin nib = shadow_n[7:4];   sup = (shadow_n[15:4]  == 12'h000); end
      2'd2: begin nib = shadow_n[11:8];  sup = (shadow_n[15:8]  == 8'h00); end
      default: begin nib = shadow_n[15:12]; sup = (shadow_n[15:12] == 4'h0); end
    endcase

    if (slot_start) begin
      data_n      = nib;
      slot_dark_n = !digit_en[rank_n] || (lz_en && sup);
    end

    blank_n      = (state_n != ST_SHOW) || slot_dark_n;
    frame_done_n = boundary && enable;
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIV=8, GUARD=2: one frame is 32
// cycles. Outputs are sampled 1 time unit after each rising edge.
module tb_display_scanner;

  localparam int DIV_T   = 8;
  localparam int GUARD_T = 2;

  logic        clk = 1'b0;
  logic        reset, enable, load, lz_en;
  logic [15:0] value_in;
  logic [3:0]  digit_en;
  logic [1:0]  rank;
  logic        blank, frame_done, pending;
  logic [3:0]  digit_data;

  logic [3:0]  nxt_den;
  logic        nxt_lz;
  int          nvec = 0;
  int          nmis = 0;

  display_scanner #(.DIV(DIV_T), .GUARD(GUARD_T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value_in(value_in),
    .load(load), .digit_en(digit_en), .lz_en(lz_en), .rank(rank),
    .blank(blank), .digit_data(digit_data), .frame_done(frame_done),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_blank(int r, int c, logic [15:0] v, logic [3:0] den, logic lz);
    logic [15:0] hi;
    logic        sup;
    hi  = v >> (4 * r);
    sup = lz && (r > 0) && (hi == 16'h0000);
    return (c < GUARD_T) || !den[r] || sup;
  endfunction

  // Checks one full frame starting at the first GUARD cycle of digit 0.
  // l1/l2 are frame cycles at which load is pulsed with v1/v2.
  task automatic run_frame(input logic [15:0] val, input logic [3:0] den, input logic lz,
                           input logic fd0, input logic p0,
                           input int l1, input logic [15:0] v1,
                           input int l2, input logic [15:0] v2);
    logic pexp;
    int   r, c;
    logic [15:0] sh;
    pexp = p0;
    for (int i = 0; i < 4 * DIV_T; i++) begin
      r  = i / DIV_T;
      c  = i % DIV_T;
      sh = val >> (4 * r);
      chk("rank", {14'd0, rank}, 16'(r));
      chk("blank", {15'd0, blank}, {15'd0, exp_blank(r, c, val, den, lz)});
      chk("digit_data", {12'd0, digit_data}, {12'd0, sh[3:0]});
      chk("frame_done", {15'd0, frame_done}, (i == 0) ? {15'd0, fd0} : 16'd0);
      chk("pending", {15'd0, pending}, {15'd0, pexp});
      load     = (i == l1) || (i == l2);
      value_in = (i == l2) ? v2 : v1;
      if (i == 4 * DIV_T - 1) begin
        digit_en = nxt_den;
        lz_en    = nxt_lz;
        pexp     = 1'b0;
      end else if (load) begin
        pexp = 1'b1;
      end
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; lz_en = 1'b0;
    value_in = 16'h0; digit_en = 4'hF;
    nxt_den = 4'hF; nxt_lz = 1'b0;
    tick(); tick();
    chk("rst_rank", {14'd0, rank}, 16'd0);
    chk("rst_blank", {15'd0, blank}, 16'd1);
    chk("rst_data", {12'd0, digit_data}, 16'd0);
    chk("rst_fdone", {15'd0, frame_done}, 16'd0);
    chk("rst_pending", {15'd0, pending}, 16'd0);
    reset = 1'b0;

    // load while idle goes straight to the shadow
    load = 1'b1; value_in = 16'h1234;
    tick();
    load = 1'b0;
    chk("idle_pending", {15'd0, pending}, 16'd0);
    chk("idle_blank", {15'd0, blank}, 16'd1);
    enable = 1'b1;
    tick();
    run_frame(16'h1234, 4'hF, 1'b0, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

    // two mid-frame loads: latest wins, ABCD never shown
    run_frame(16'h1234, 4'hF, 1'b0, 1'b1, 1'b0, 5, 16'hABCD, 12, 16'h5678);
    nxt_den = 4'b1011;
    run_frame(16'h5678, 4'hF, 1'b0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    // digit 2 masked; 0040 committed at the boundary together with lz_en
    nxt_den = 4'hF; nxt_lz = 1'b1;
    run_frame(16'h5678, 4'b1011, 1'b0, 1'b1, 1'b0, 31, 16'h0040, -1, 16'h0);
    run_frame(16'h0040, 4'hF, 1'b1, 1'b1, 1'b0, 31, 16'h0000, -1, 16'h0);

    // parked AAAA discarded by a load coincident with the boundary
    nxt_lz = 1'b0;
    run_frame(16'h0000, 4'hF, 1'b1, 1'b1, 1'b0, 10, 16'hAAAA, 31, 16'h1234);
    run_frame(16'h1234, 4'hF, 1'b0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    // drop enable in the rank-2 SHOW phase
    for (int i = 0; i < 2 * DIV_T + 3; i++) tick();
    chk("pre_drop_rank", {14'd0, rank}, 16'd2);
    chk("pre_drop_blank", {15'd0, blank}, 16'd0);
    enable = 1'b0;
    tick();
    chk("drop_rank", {14'd0, rank}, 16'd0);
    chk("drop_blank", {15'd0, blank}, 16'd1);
    chk("drop_fdone", {15'd0, frame_done}, 16'd0);
    tick();
    chk("idle_hold_blank", {15'd0, blank}, 16'd1);
    enable = 1'b1;
    tick();
    run_frame(16'h1234, 4'hF, 1'b0, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

    // reset mid-SHOW wins over load and enable
    tick(); tick(); tick();
    chk("pre_rst_blank", {15'd0, blank}, 16'd0);
    reset = 1'b1; load = 1'b1; value_in = 16'hFFFF;
    tick();
    chk("mid_rst_rank", {14'd0, rank}, 16'd0);
    chk("mid_rst_blank", {15'd0, blank}, 16'd1);
    chk("mid_rst_data", {12'd0, digit_data}, 16'd0);
    chk("mid_rst_fdone", {15'd0, frame_done}, 16'd0);
    chk("mid_rst_pending", {15'd0, pending}, 16'd0);
    reset = 1'b0; load = 1'b0;
    tick();
    chk("post_rst_data", {12'd0, digit_data}, 16'd0);
    chk("post_rst_blank", {15'd0, blank}, 16'd1);
    chk("post_rst_rank", {14'd0, rank}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot (legal range 4..65535).
REQ-002 SHALL have parameter GUARD, default 500, meaning blanked cycles at the start of each slot (anti-ghosting; legal range 1..DIV-1).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  1 = scanning runs; 0 = display dark, scanner idle.
REQ-006 SHALL have port value_in  input  16  four hex digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
REQ-007 SHALL have port load  input  1  one-cycle strobe that captures value_in.
REQ-008 SHALL have port digit_en  input  4  per-digit enable mask; bit k = 0 keeps digit k dark.
REQ-009 SHALL have port lz_en  input  1  1 = leading-zero suppression active.
REQ-010 SHALL have port rank  output  2  index of the digit currently driven, for the 7-segment digit decoder.
REQ-011 SHALL have port blank  output  1  anode level for the selected digit; 0 = lit, 1 = dark.
REQ-012 SHALL have port digit_data  output  4  hex nibble for the selected digit.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the digit 3 slot ends.
REQ-014 SHALL have port pending  output  1  1 = a loaded value is waiting for the next frame boundary.

Function
REQ-015 SHALL implement states IDLE, GUARD and SHOW; enable=0 forces IDLE from any state on the next edge.
REQ-016 IDLE: SHALL hold slot_cnt=0, rank=0, blank=1, frame_done=0; enable=1 SHALL move the block to GUARD on the next edge.
REQ-017 SHALL use a slot counter slot_cnt running 0..DIV-1 in GUARD/SHOW; GUARD SHALL cover slot_cnt<GUARD and SHOW SHALL cover GUARD..DIV-1.
REQ-018 At slot_cnt=DIV-1, SHALL wrap slot_cnt to 0, advance rank by 1 mod 4 (3->0) and enter GUARD.
REQ-019 In GUARD, blank SHALL be 1.
REQ-020 In SHOW, blank SHALL be 0 unless digit_en[rank]=0 or digit rank is suppressed (REQ-021).
REQ-021 With lz_en=1, digit k (k=3..1) SHALL be suppressed when its nibble and every higher nibble in the shadow register are 0; digit 0 SHALL never be suppressed.
REQ-022 digit_data SHALL equal shadow[4*rank+3:4*rank], registered, and SHALL change only at slot start, never mid-SHOW.
REQ-023 frame_done SHALL pulse for exactly the cycle after rank wraps 3->0 (the first GUARD cycle of digit 0).
REQ-024 Load in GUARD/SHOW, not at a frame boundary: value_in SHALL go into the pending register and pending SHALL be set; a later load before the boundary SHALL overwrite it (latest wins).
REQ-025 At the frame boundary (rank 3, slot_cnt=DIV-1): if pending=1, shadow SHALL take the pending register and pending SHALL clear.
REQ-026 Load coincident with the frame boundary: shadow SHALL take value_in directly and pending SHALL clear; an older pending value SHALL be discarded.
REQ-027 Load in IDLE: shadow SHALL take value_in immediately and pending SHALL remain 0.
REQ-028 Changes to digit_en and lz_en SHALL take effect at the next slot start.
REQ-029 Output latency SHALL be 1 cycle from the state/counter change to the registered outputs; all outputs SHALL be registered.

Reset
REQ-030 reset=1 SHALL, on the next edge, force IDLE, slot_cnt=0, rank=0, blank=1, digit_data=0, frame_done=0, pending=0, shadow=0 and pending register=0.
REQ-031 reset SHALL take priority over enable and load, including mid-slot and during a frame boundary.

Verification (DIV=8, GUARD=2)
REQ-032 Reset, then enable=1 with load of value_in=16'h1234 while idle -> shadow=1234, rank sequence 0,1,2,3 with 8 cycles each, digit_data 4,3,2,1, blank 1 for 2 cycles then 0 for 6 in each slot, frame_done pulses every 32 cycles.
REQ-033 Load of 16'hABCD mid-frame, then load of 16'h5678 in the same frame -> pending=1 until the boundary; the next frame shows 8,7,6,5; ABCD never appears.
REQ-034 lz_en=1 with shadow=16'h0040 -> digits 3 and 2 stay dark, digit 1 shows 4, digit 0 shows 0; shadow=16'h0000 -> only digit 0 is lit, showing 0.
REQ-035 digit_en=4'b1011 -> blank=1 for the whole rank-2 slot; the other slots follow REQ-032 timing.
REQ-036 enable dropped during the rank-2 SHOW -> next cycle IDLE, blank=1, rank=0; enable reasserted -> scan restarts at rank 0 in GUARD with no frame_done.
REQ-037 Load asserted exactly at the rank-3 slot_cnt=7 cycle -> new value displayed from the next frame, pending=0 afterwards; reset asserted mid-SHOW -> all REQ-030 values on the next edge.
